bus_arbiter_ctrl: RTL and testbench
===================================

// Module: bus_arbiter_ctrl
// PURPOSE
//  Two-master memory-bus arbiter/sequencer between CPU, DRAM and I/O registers.
//  - Master 0 is the CPU load/store port; master 1 is a secondary requester, e.g. a debug/DMA reader.
//  - Arbitrates one transaction at a time and decodes each address to DRAM or a local I/O register.
//  - I/O registers: LED word, 7-seg word, switch input.
//  - Sequences the fixed DRAM read latency and returns a one-cycle ack to the granted master.
// PARAMETERS
//  RD_LAT      2             DRAM read latency in cycles, mem_en to valid mem_rdata (1..7)
//  IO_BASE     32'hFFFF_F000 addresses >= IO_BASE are I/O, otherwise DRAM
//  SEG_OFS     12'h000       7-seg data register offset from IO_BASE
//  LED_OFS     12'h060       LED register offset (24 bits used)
//  SW_OFS      12'h070       switch register offset (read-only, 24 bits, zero-extended)
// PORTS
//  clk         in   1   system clock; all logic on rising edge
//  rst         in   1   reset, synchronous, active-high
//  m0_req      in   1   master 0 request; held until m0_ack
//  m0_we       in   1   master 0 write enable
//  m0_addr     in   32  master 0 byte address
//  m0_wdata    in   32  master 0 write data
//  m0_ack      out  1   one-cycle completion pulse to master 0
//  m0_rdata    out  32  read data; valid in the m0_ack cycle
//  m1_req/m1_we/m1_addr/m1_wdata/m1_ack/m1_rdata   same as master 0, for master 1
//  mem_en      out  1   DRAM access strobe, one cycle
//  mem_we      out  1   DRAM write enable, qualified by mem_en
//  mem_addr    out  32  DRAM address
//  mem_wdata   out  32  DRAM write data
//  mem_rdata   in   32  DRAM read data, valid RD_LAT cycles after mem_en
//  device_sw   in   24  board switches
//  device_led  out  24  LED register contents
//  seg_data    out  32  7-seg register contents, to the display scanner
//  seg_we      out  1   one-cycle pulse when seg_data is written
// BEHAVIOUR
//  - Reset values: all acks, mem_en, mem_we and seg_we are 0; device_led, seg_data, rdata and mem_* buses are 0; FSM goes to IDLE; last_grant=1, so m0 wins first.
//  - FSM states: IDLE, ISSUE, WAIT, ACK.
//    - IDLE: if any req is asserted, latch the winner's we/addr/wdata and grant id, then go to ISSUE. Otherwise stay.
//    - ISSUE, DRAM address: pulse mem_en for one cycle.
//      - Write: go to ACK.
//      - Read: load the latency counter with RD_LAT-1 and go to WAIT. If RD_LAT==1, go straight to ACK and capture mem_rdata there.
//    - ISSUE, I/O address: the access completes locally this cycle; go to ACK.
//      - LED write: device_led <= wdata[23:0].
//      - 7-seg write: seg_data <= wdata and pulse seg_we.
//      - SW read: rdata = {8'h0, device_sw}, sampled this cycle.
//      - LED or 7-seg read returns the current register value.
//      - Write to SW, or any access to an unmapped I/O offset: no side effect, rdata=0, still acked.
//    - WAIT: decrement the counter; at 0, capture mem_rdata and go to ACK.
//    - ACK: pulse the granted master's ack with rdata for exactly one cycle, update last_grant, return to IDLE.
//  - Latency from req to ack:
//    - DRAM write: 3 cycles.
//    - DRAM read: 2+RD_LAT cycles.
//    - I/O access: 3 cycles.
//  - The next grant is possible in the cycle after ACK. There is no back-to-back grant in the ACK cycle.
//  - Masters must hold req/we/addr/wdata stable until their ack. The arbiter latches these at grant.
//  - A req dropped early is a protocol violation; the transaction still completes and acks.
//  - Non-granted masters see ack=0 and their rdata held at its last value.
//  - Address decode is an unsigned compare: addr >= IO_BASE means I/O, and addr[11:0] is the offset. Decode is made once, at grant.
//  - Reset mid-transaction aborts it, with no ack. A DRAM read already issued is discarded.
//  - Only one mem_en is outstanding at any time.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN defined: when both reqs are asserted in IDLE, grant goes to the master not in last_grant (alternating).
//  ARB_ROUND_ROBIN_EN undefined: fixed priority; m0 always wins a tie. last_grant is still kept but ignored.
//  Single requests are granted identically in both builds.
// TESTING
//  1. DRAM read, RD_LAT=2: m0 read 0x10, DRAM returns 0xDEADBEEF -> mem_en at cycle 1, m0_ack at cycle 4, m0_rdata=0xDEADBEEF.
//  2. LED write: m0 writes 0x00A5A5A5 to 0xFFFFF060 -> device_led=0xA5A5A5 after ISSUE, m0_ack at cycle 3, mem_en never asserted.
//  3. SW read: device_sw=0x123456, m1 reads 0xFFFFF070 -> m1_rdata=0x00123456, and m0_ack stays 0 throughout.
//  4. Contention: m0 and m1 both request continuously for 4 transactions.
//     - With ARB_ROUND_ROBIN_EN: grant order is m0,m1,m0,m1.
//     - Without it: order is m0,m0,m0,m0 while m0_req is held.
//  5. Reset abort: assert rst during WAIT of a DRAM read -> no ack, all outputs 0 the next cycle, and the next request completes normally.
//  6. Unmapped I/O: m0 writes 0xFFFFF0F0 -> acked with rdata 0, device_led and seg_data unchanged, seg_we=0.

Source files
------------

// File: rtl/bus_arbiter_ctrl.sv
// rtl/bus_arbiter_ctrl.sv - two-master memory bus arbiter with DRAM / I/O register decode
//
// Purpose:
//   Arbitrates one transaction at a time between master 0 (CPU load/store)
//   and master 1 (debug/DMA reader). Each address is decoded once, at grant,
//   either to DRAM (fixed read latency RD_LAT) or to a local I/O register
//   (LED word, 7-seg word, switch input). The granted master gets a
//   one-cycle ack with its read data.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   m0_req/we/addr/wdata         master 0 request (held until m0_ack)
//   m0_ack, m0_rdata             master 0 completion pulse and read data
//   m1_*                         same as master 0, for master 1
//   mem_en/we/addr/wdata         DRAM access strobe and command (one cycle)
//   mem_rdata                    DRAM read data, valid RD_LAT cycles after mem_en
//   device_sw                    board switches (read-only register)
//   device_led                   LED register contents
//   seg_data, seg_we             7-seg register contents and write pulse
//
// Build option:
//   ARB_ROUND_ROBIN_EN  defined: ties alternate, starting away from last_grant.
//                       undefined: fixed priority, master 0 wins ties.

module bus_arbiter_ctrl #(
   parameter int unsigned RD_LAT  = 2,
   parameter logic [31:0] IO_BASE = 32'hFFFF_F000,
   parameter logic [11:0] SEG_OFS = 12'h000,
   parameter logic [11:0] LED_OFS = 12'h060,
   parameter logic [11:0] SW_OFS  = 12'h070
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m0_req,
   input  logic        m0_we,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   output logic        m0_ack,
   output logic [31:0] m0_rdata,
   input  logic        m1_req,
   input  logic        m1_we,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   output logic        m1_ack,
   output logic [31:0] m1_rdata,
   output logic        mem_en,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic [23:0] device_sw,
   output logic [23:0] device_led,
   output logic [31:0] seg_data,
   output logic        seg_we
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_ACK
   } state_t;

   localparam logic [2:0] LAT_LOAD = 3'(RD_LAT - 1);

   state_t      state;
   state_t      state_next;
   logic [2:0]  lat_cnt;
   logic [2:0]  lat_cnt_next;
   logic        grant_take;

   // winner selection
   logic        win_id;
   logic        win_we;
   logic [31:0] win_addr;
   logic [31:0] win_wdata;

   // transaction latched at grant
   logic        cur_id;
   logic        cur_we;
   logic        cur_io;
   logic [31:0] cur_addr;
   logic [31:0] cur_wdata;

   logic        last_grant;
   logic [31:0] xfer_rdata;
   logic [31:0] io_rdata;
   logic [31:0] ack_rdata;
   logic        led_wr;
   logic        seg_wr;
   logic        ack_busy;
   logic        is_dram_rd;

   logic [23:0] led_q;
   logic [31:0] seg_q;
   logic        seg_we_q;
   logic        m0_ack_q;
   logic        m1_ack_q;
   logic [31:0] m0_rdata_q;
   logic [31:0] m1_rdata_q;

   // The ack is registered, so it is visible while the FSM already sits in
   // IDLE. The acked master still holds req in that cycle; granting then
   // would replay its finished transaction, so IDLE waits one cycle.
   assign ack_busy = m0_ack_q | m1_ack_q;

`ifdef ARB_ROUND_ROBIN_EN
   assign win_id = (m0_req && m1_req) ? ~last_grant : ~m0_req;
`else
   assign win_id = ~m0_req;
   // last_grant is tracked but has no effect on arbitration in this build.
   logic unused_last_grant;
   assign unused_last_grant = last_grant;
`endif

   assign win_we    = win_id ? m1_we    : m0_we;
   assign win_addr  = win_id ? m1_addr  : m0_addr;
   assign win_wdata = win_id ? m1_wdata : m0_wdata;

   assign is_dram_rd = !cur_io && !cur_we;

   // For DRAM reads the data arrives on mem_rdata in the ACK cycle itself;
   // everything else was resolved during ISSUE.
   assign ack_rdata = is_dram_rd ? mem_rdata : xfer_rdata;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         lat_cnt <= 3'd0;
      end else begin
         state   <= state_next;
         lat_cnt <= lat_cnt_next;
      end
   end

   always_comb begin
      state_next   = state;
      lat_cnt_next = lat_cnt;
      grant_take   = 1'b0;
      case (state)
         ST_IDLE: begin
            if ((m0_req || m1_req) && !ack_busy) begin
               grant_take = 1'b1;
               state_next = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (is_dram_rd && (RD_LAT > 1)) begin
               lat_cnt_next = LAT_LOAD;
               state_next   = ST_WAIT;
            end else begin
               state_next = ST_ACK;
            end
         end
         ST_WAIT: begin
            lat_cnt_next = lat_cnt - 3'd1;
            if (lat_cnt == 3'd1) begin
               state_next = ST_ACK;
            end
         end
         ST_ACK: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Local I/O register decode, active only in ISSUE for an I/O transaction.
   // Unmapped offsets and writes to the switch register fall through with
   // no side effect and zero read data.
   always_comb begin
      io_rdata = 32'h0;
      led_wr   = 1'b0;
      seg_wr   = 1'b0;
      if (state == ST_ISSUE && cur_io) begin
         if (cur_addr[11:0] == LED_OFS) begin
            if (cur_we) begin
               led_wr = 1'b1;
            end else begin
               io_rdata = {8'h0, led_q};
            end
         end else if (cur_addr[11:0] == SEG_OFS) begin
            if (cur_we) begin
               seg_wr = 1'b1;
            end else begin
               io_rdata = seg_q;
            end
         end else if (cur_addr[11:0] == SW_OFS) begin
            if (!cur_we) begin
               io_rdata = {8'h0, device_sw};
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cur_id     <= 1'b0;
         cur_we     <= 1'b0;
         cur_io     <= 1'b0;
         cur_addr   <= 32'h0;
         cur_wdata  <= 32'h0;
         last_grant <= 1'b1;
         xfer_rdata <= 32'h0;
         led_q      <= 24'h0;
         seg_q      <= 32'h0;
         seg_we_q   <= 1'b0;
         m0_ack_q   <= 1'b0;
         m1_ack_q   <= 1'b0;
         m0_rdata_q <= 32'h0;
         m1_rdata_q <= 32'h0;
      end else begin
         if (grant_take) begin
            cur_id    <= win_id;
            cur_we    <= win_we;
            cur_io    <= (win_addr >= IO_BASE);
            cur_addr  <= win_addr;
            cur_wdata <= win_wdata;
         end

         if (state == ST_ISSUE) begin
            xfer_rdata <= io_rdata;
         end

         if (led_wr) begin
            led_q <= cur_wdata[23:0];
         end

         seg_we_q <= seg_wr;
         if (seg_wr) begin
            seg_q <= cur_wdata;
         end

         m0_ack_q <= (state == ST_ACK) && !cur_id;
         m1_ack_q <= (state == ST_ACK) && cur_id;

         if (state == ST_ACK) begin
            last_grant <= cur_id;
            if (cur_id) begin
               m1_rdata_q <= ack_rdata;
            end else begin
               m0_rdata_q <= ack_rdata;
            end
         end
      end
   end

   assign mem_en    = (state == ST_ISSUE) && !cur_io;
   assign mem_we    = mem_en && cur_we;
   assign mem_addr  = mem_en ? cur_addr  : 32'h0;
   assign mem_wdata = mem_en ? cur_wdata : 32'h0;

   assign m0_ack     = m0_ack_q;
   assign m1_ack     = m1_ack_q;
   assign m0_rdata   = m0_rdata_q;
   assign m1_rdata   = m1_rdata_q;
   assign device_led = led_q;
   assign seg_data   = seg_q;
   assign seg_we     = seg_we_q;

endmodule

// File: tb/tb_bus_arbiter_ctrl.sv
// tb/tb_bus_arbiter_ctrl.sv - directed self-checking bench for bus_arbiter_ctrl

module tb_bus_arbiter_ctrl;

   localparam int RD_LAT = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        m0_req, m0_we, m1_req, m1_we;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic        m0_ack, m1_ack;
   logic [31:0] m0_rdata, m1_rdata;
   logic        mem_en, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [23:0] device_sw, device_led;
   logic [31:0] seg_data;
   logic        seg_we;

   int checks = 0;
   int failures = 0;

   // results of the most recent run_xfer
   int          r_ack_cyc;
   int          r_en_cnt;
   int          r_en_first;
   int          r_seg_we_cnt;
   int          r_other_ack;
   logic [31:0] r_rdata;

   always #5 clk = ~clk;

   bus_arbiter_ctrl #(.RD_LAT(RD_LAT)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_ack(m0_ack), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_ack(m1_ack), .m1_rdata(m1_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .device_sw(device_sw), .device_led(device_led),
      .seg_data(seg_data), .seg_we(seg_we)
   );

   // DRAM model: 16 words, fixed read latency, poison value when idle
   logic [31:0] mem [16];
   logic [31:0] rd_pipe [RD_LAT];

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) mem[i] <= 32'hA000_0000 + i;
         mem[4]  <= 32'hDEAD_BEEF;
         mem[15] <= 32'h5555_AAAA;
      end else if (mem_en && mem_we) begin
         mem[mem_addr[5:2]] <= mem_wdata;
      end
      rd_pipe[0] <= (mem_en && !mem_we) ? mem[mem_addr[5:2]] : 32'h0BAD_0BAD;
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end

   assign mem_rdata = rd_pipe[RD_LAT-1];

   task automatic reset_dut();
      rst = 1'b1;
      m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
      m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // One transaction; cycle 0 is the cycle req is first driven.
   task automatic run_xfer(input bit id, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
      r_ack_cyc = -1; r_en_cnt = 0; r_en_first = -1; r_seg_we_cnt = 0; r_other_ack = 0; r_rdata = 32'hx;
      @(posedge clk); #1;
      if (id) begin m1_req = 1; m1_we = we; m1_addr = addr; m1_wdata = wdata; end
      else    begin m0_req = 1; m0_we = we; m0_addr = addr; m0_wdata = wdata; end
      for (int cyc = 0; cyc < 30; cyc++) begin
         @(negedge clk);
         if (mem_en) begin r_en_cnt++; if (r_en_first < 0) r_en_first = cyc; end
         if (seg_we) r_seg_we_cnt++;
         if (id ? m0_ack : m1_ack) r_other_ack++;
         if (id ? m1_ack : m0_ack) begin r_ack_cyc = cyc; r_rdata = id ? m1_rdata : m0_rdata; break; end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      m0_req = 0; m1_req = 0;
   endtask

   task automatic test_reset();
      reset_dut();
      @(negedge clk);
      checks++; if ({m0_ack, m1_ack, mem_en, mem_we, seg_we} !== 5'b0) begin failures++; $display("FAIL reset_strobes got=%b exp=00000", {m0_ack, m1_ack, mem_en, mem_we, seg_we}); end
      checks++; if (device_led !== 24'h0) begin failures++; $display("FAIL reset_led got=%h exp=000000", device_led); end
      checks++; if (seg_data !== 32'h0) begin failures++; $display("FAIL reset_seg got=%h exp=00000000", seg_data); end
      checks++; if ({m0_rdata, m1_rdata} !== 64'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", {m0_rdata, m1_rdata}); end
      checks++; if ({mem_addr, mem_wdata} !== 64'h0) begin failures++; $display("FAIL reset_mem_bus got=%h exp=0", {mem_addr, mem_wdata}); end
   endtask

   task automatic test_dram_read();
      run_xfer(0, 0, 32'h0000_0010, 32'h0);
      checks++; if (r_en_first !== 1) begin failures++; $display("FAIL rd_mem_en_cycle got=%0d exp=1", r_en_first); end
      checks++; if (r_en_cnt !== 1) begin failures++; $display("FAIL rd_mem_en_count got=%0d exp=1", r_en_cnt); end
      checks++; if (r_ack_cyc !== 4) begin failures++; $display("FAIL rd_ack_cycle got=%0d exp=4", r_ack_cyc); end
      checks++; if (r_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rd_data got=%h exp=deadbeef", r_rdata); end
      checks++; if (r_other_ack !== 0) begin failures++; $display("FAIL rd_m1_ack got=%0d exp=0", r_other_ack); end
      @(negedge clk);
      checks++; if (m0_ack !== 1'b0) begin failures++; $display("FAIL rd_ack_one_cycle got=%b exp=0", m0_ack); end
   endtask

   task automatic test_dram_write();
      run_xfer(1, 1, 32'h0000_0020, 32'hCAFE_F00D);
      checks++; if (r_ack_cyc !== 3) begin failures++; $display("FAIL wr_ack_cycle got=%0d exp=3", r_ack_cyc); end
      checks++; if (r_en_cnt !== 1) begin failures++; $display("FAIL wr_mem_en_count got=%0d exp=1", r_en_cnt); end
      checks++; if (mem[8] !== 32'hCAFE_F00D) begin failures++; $display("FAIL wr_mem_word got=%h exp=cafef00d", mem[8]); end
      checks++; if (m0_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wr_m0_rdata_hold got=%h exp=deadbeef", m0_rdata); end
      run_xfer(1, 0, 32'h0000_0020, 32'h0);
      checks++; if (r_rdata !== 32'hCAFE_F00D) begin failures++; $display("FAIL wr_readback got=%h exp=cafef00d", r_rdata); end
      checks++; if (r_ack_cyc !== 4) begin failures++; $display("FAIL wr_readback_cycle got=%0d exp=4", r_ack_cyc); end
   endtask

   task automatic test_led_write();
      run_xfer(0, 1, 32'hFFFF_F060, 32'h00A5_A5A5);
      checks++; if (r_ack_cyc !== 3) begin failures++; $display("FAIL led_ack_cycle got=%0d exp=3", r_ack_cyc); end
      checks++; if (r_en_cnt !== 0) begin failures++; $display("FAIL led_mem_en got=%0d exp=0", r_en_cnt); end
      checks++; if (device_led !== 24'hA5_A5A5) begin failures++; $display("FAIL led_value got=%h exp=a5a5a5", device_led); end
      run_xfer(1, 0, 32'hFFFF_F060, 32'h0);
      checks++; if (r_rdata !== 32'h00A5_A5A5) begin failures++; $display("FAIL led_readback got=%h exp=00a5a5a5", r_rdata); end
   endtask

   task automatic test_sw_read();
      device_sw = 24'h12_3456;
      run_xfer(1, 0, 32'hFFFF_F070, 32'h0);
      checks++; if (r_rdata !== 32'h0012_3456) begin failures++; $display("FAIL sw_rdata got=%h exp=00123456", r_rdata); end
      checks++; if (r_other_ack !== 0) begin failures++; $display("FAIL sw_m0_ack got=%0d exp=0", r_other_ack); end
      checks++; if (r_ack_cyc !== 3) begin failures++; $display("FAIL sw_ack_cycle got=%0d exp=3", r_ack_cyc); end
   endtask

   task automatic test_seg_write();
      run_xfer(0, 1, 32'hFFFF_F000, 32'h1234_5678);
      checks++; if (seg_data !== 32'h1234_5678) begin failures++; $display("FAIL seg_value got=%h exp=12345678", seg_data); end
      checks++; if (r_seg_we_cnt !== 1) begin failures++; $display("FAIL seg_we_pulses got=%0d exp=1", r_seg_we_cnt); end
      checks++; if (r_en_cnt !== 0) begin failures++; $display("FAIL seg_mem_en got=%0d exp=0", r_en_cnt); end
   endtask

   task automatic test_unmapped();
      run_xfer(0, 0, 32'hFFFF_F060, 32'h0);
      checks++; if (r_rdata !== 32'h00A5_A5A5) begin failures++; $display("FAIL unm_pre_led_read got=%h exp=00a5a5a5", r_rdata); end
      run_xfer(0, 1, 32'hFFFF_F0F0, 32'hFFFF_FFFF);
      checks++; if (r_ack_cyc !== 3) begin failures++; $display("FAIL unm_ack_cycle got=%0d exp=3", r_ack_cyc); end
      checks++; if (r_rdata !== 32'h0) begin failures++; $display("FAIL unm_rdata got=%h exp=00000000", r_rdata); end
      checks++; if (device_led !== 24'hA5_A5A5) begin failures++; $display("FAIL unm_led got=%h exp=a5a5a5", device_led); end
      checks++; if (seg_data !== 32'h1234_5678) begin failures++; $display("FAIL unm_seg got=%h exp=12345678", seg_data); end
      checks++; if (r_seg_we_cnt !== 0) begin failures++; $display("FAIL unm_seg_we got=%0d exp=0", r_seg_we_cnt); end
      run_xfer(0, 1, 32'hFFFF_F070, 32'hFFFF_FFFF);
      checks++; if (device_led !== 24'hA5_A5A5) begin failures++; $display("FAIL sw_write_led got=%h exp=a5a5a5", device_led); end
      run_xfer(1, 0, 32'hFFFF_F0F0, 32'h0);
      checks++; if (r_rdata !== 32'h0) begin failures++; $display("FAIL unm_read got=%h exp=00000000", r_rdata); end
   endtask

   task automatic test_io_boundary();
      run_xfer(1, 0, 32'hFFFF_EFFC, 32'h0);
      checks++; if (r_en_cnt !== 1) begin failures++; $display("FAIL below_base_mem_en got=%0d exp=1", r_en_cnt); end
      checks++; if (r_rdata !== 32'h5555_AAAA) begin failures++; $display("FAIL below_base_rdata got=%h exp=5555aaaa", r_rdata); end
      run_xfer(0, 0, 32'hFFFF_F000, 32'h0);
      checks++; if (r_en_cnt !== 0) begin failures++; $display("FAIL at_base_mem_en got=%0d exp=0", r_en_cnt); end
      checks++; if (r_rdata !== 32'h1234_5678) begin failures++; $display("FAIL at_base_rdata got=%h exp=12345678", r_rdata); end
   endtask

   task automatic test_reset_abort();
      int acks;
      acks = 0;
      @(posedge clk); #1;
      m0_req = 1; m0_we = 0; m0_addr = 32'h0000_0010; m0_wdata = 0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; m0_req = 0;
      @(negedge clk);
      checks++; if ({m0_ack, m1_ack, mem_en, seg_we} !== 4'b0) begin failures++; $display("FAIL abort_strobes got=%b exp=0000", {m0_ack, m1_ack, mem_en, seg_we}); end
      checks++; if ({device_led, seg_data} !== 56'h0) begin failures++; $display("FAIL abort_regs got=%h exp=0", {device_led, seg_data}); end
      checks++; if ({m0_rdata, m1_rdata, mem_addr} !== 96'h0) begin failures++; $display("FAIL abort_buses got=%h exp=0", {m0_rdata, m1_rdata, mem_addr}); end
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (m0_ack || m1_ack) acks++;
      end
      checks++; if (acks !== 0) begin failures++; $display("FAIL abort_late_ack got=%0d exp=0", acks); end
      run_xfer(1, 0, 32'h0000_0010, 32'h0);
      checks++; if (r_ack_cyc !== 4) begin failures++; $display("FAIL abort_next_cycle got=%0d exp=4", r_ack_cyc); end
      checks++; if (r_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL abort_next_rdata got=%h exp=deadbeef", r_rdata); end
   endtask

   task automatic test_contention();
      logic [3:0] order;
      logic [3:0] exp_order;
      int         ack_cyc [4];
      int         n;
`ifdef ARB_ROUND_ROBIN_EN
      exp_order = 4'b1010;
`else
      exp_order = 4'b0000;
`endif
      order = 4'b0;
      n = 0;
      for (int i = 0; i < 4; i++) ack_cyc[i] = -1;
      reset_dut();
      @(posedge clk); #1;
      m0_req = 1; m0_we = 0; m0_addr = 32'hFFFF_F060;
      m1_req = 1; m1_we = 0; m1_addr = 32'hFFFF_F070;
      for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
         @(negedge clk);
         if (m0_ack || m1_ack) begin
            order[n] = m1_ack;
            ack_cyc[n] = cyc;
            n++;
         end
         @(posedge clk); #1;
      end
      m0_req = 0; m1_req = 0;
      checks++; if (n !== 4) begin failures++; $display("FAIL cont_ack_count got=%0d exp=4", n); end
      checks++; if (order !== exp_order) begin failures++; $display("FAIL cont_order got=%b exp=%b", order, exp_order); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (ack_cyc[i] !== 3 + 4 * i) begin failures++; $display("FAIL cont_ack_cycle_%0d got=%0d exp=%0d", i, ack_cyc[i], 3 + 4 * i); end
      end
   endtask

   initial begin
      device_sw = 24'h0;
      test_reset();
      test_dram_read();
      test_dram_write();
      test_led_write();
      test_sw_read();
      test_seg_write();
      test_unmapped();
      test_io_boundary();
      test_reset_abort();
      test_contention();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
